rgb_video_rx: RTL
=================

Name: rgb_video_rx

Overview:
- Receiver/checker for the parallel RGB565 LCD interface: samples dclk/de/hs/vs/rgb as driven to the panel and recovers frame timing.
- Outputs per-pixel coordinates and data, measured timing, lock status and an optional per-frame CRC.
- Used as a loopback monitor for the LCD pipeline, and as the capture front end for on-chip display self-test.
- Entirely in the dclk domain.

Parameters:
- H_ACTIVE, 480, expected de-high pixels per active line.
- V_ACTIVE, 272, expected active lines per frame.
- HS_POL, 1'b0, asserted level of hs.
- VS_POL, 1'b0, asserted level of vs.
- LOCK_FRAMES, 2, consecutive conforming frames required to lock (1..15).

Ports:
- dclk  in  1  pixel clock; reset asynchronous, active-high; clock dclk.
- reset  in  1  asynchronous active-high reset.
- de  in  1  data enable.
- hs  in  1  horizontal sync.
- vs  in  1  vertical sync.
- r  in  5  red.
- g  in  6  green.
- b  in  5  blue.
- pix_valid  out  1  active pixel on pix_rgb.
- pix_x  out  10  column of the current pixel.
- pix_y  out  10  row of the current pixel.
- pix_rgb  out  16  {r,g,b}.
- frame_start  out  1  one-cycle pulse at vs assertion while locked.
- locked  out  1  timing lock.
- err_timing  out  1  one-cycle pulse on lock loss.
- meas_h_active  out  12  de cycles in the last active line.
- meas_h_total  out  12  dclk cycles between the last two hs assertions.
- meas_v_active  out  12  active lines in the last frame.
- meas_v_total  out  12  hs assertions in the last frame.
- frame_crc  out  16  CRC of the last frame.
- crc_valid  out  1  one-cycle pulse when frame_crc updates.

Behaviour:
- Inputs are registered once (stage S1). Edge detection compares S1 with a second register, S2. All outputs are registered.
- pix_valid/pix_x/pix_y/pix_rgb appear 2 dclk after the input sampling edge.
- Reset: all outputs 0, FSM in SEARCH, all counters 0.
- "hs assertion" = S1 hs == HS_POL and S2 hs != HS_POL. vs assertion is defined the same way with VS_POL.
- h_cnt: 12-bit counter, cleared to 1 on hs assertion, otherwise +1, saturating at 4095. On hs assertion, meas_h_total <= h_cnt.
- de_cnt: counts de-high cycles, cleared on hs assertion. On de falling edge, meas_h_active <= de_cnt.
- Line and frame counters:
  - line_cnt counts hs assertions; act_cnt counts de falling edges. Both are cleared on vs assertion.
  - On vs assertion, meas_v_total <= line_cnt and meas_v_active <= act_cnt.
  - The first vs assertion after reset or SEARCH entry does not publish measurements.
- pix_x = de_cnt value before increment. pix_y = act_cnt. Width: the low 10 bits are used.
- pix_valid = S1 de & locked.
- FSM states:
  - SEARCH: wait for vs assertion, then go to MEASURE with good_cnt = 0.
  - MEASURE: at each vs assertion, if the frame conformed, good_cnt++, else good_cnt = 0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: on a violation, go to SEARCH, pulse err_timing and drop locked the same cycle. Otherwise stay.
- Frame conformance requires all of:
  - every de run == H_ACTIVE;
  - active lines == V_ACTIVE;
  - every meas_h_total within a frame equal to the first one of that frame;
  - no de high while vs asserted.
- Violations in LOCKED:
  - A de run != H_ACTIVE is flagged at its de falling edge.
  - An active-line mismatch is flagged at vs assertion.
  - h_cnt reaching 4095 (hs lost) is flagged when saturation occurs.
  - de while vs asserted is flagged immediately.
- locked: 1 in LOCKED only. frame_start fires only in LOCKED, on the same vs assertion that publishes measurements.
- Simultaneous hs and vs assertion: line counting happens first (the hs counts toward the ending frame), then frame publish.
- A de run that spans an hs assertion: de_cnt restarts and the run length is invalid, which is a violation.
- Reset mid-frame: immediate return to reset state; lock requires LOCK_FRAMES fresh frames after the first vs.

Optional Feature:
- RGB_VIDEO_RX_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final xor) over pix_rgb, MSB first, 16 bits per active pixel, in raster order.
  - The running CRC is re-initialised on vs assertion.
  - On vs assertion in LOCKED, frame_crc <= running value and crc_valid pulses 1 cycle.
- Not defined: frame_crc and crc_valid are held 0; no CRC logic is synthesised.

Test Plan:
1. Drive a 480x272 source (H_TOTAL 525, V_TOTAL 286, both pols 0) from reset. At the 3rd vs assertion: locked=1, frame_start pulse, meas_h_active=480, meas_h_total=525, meas_v_active=272, meas_v_total=286.
2. Locked, one line with a 479-cycle de run. At that de fall: err_timing pulse, locked=0. Relock after 2 further clean frames.
3. Locked, checkerboard content. The first active pixel gives pix_x=0, pix_y=0, pix_valid 2 cycles after sampling. The last gives pix_x=479, pix_y=271. pix_rgb matches input.
4. Hold hs deasserted for 4095 cycles while locked -> err_timing, locked=0, FSM in SEARCH.
5. Assert reset mid-frame in LOCKED -> all outputs 0 immediately. Lock returns only at the 3rd subsequent vs assertion.
6. With RGB_VIDEO_RX_CRC_EN, an all-0xFFFF frame -> crc_valid pulse, frame_crc equal to the reference-model value, identical over two frames. Without the macro, crc_valid stays 0.

Source files
------------

// File: rtl/rgb_video_rx.sv
// RGB565 parallel-LCD receiver: recovers frame timing, locks to a conforming source and
// reports per-pixel data and measured timing. Macro RGB_VIDEO_RX_CRC_EN adds a per-frame CRC-16.
module rgb_video_rx #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned V_ACTIVE    = 272,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        dclk,
    input  logic        reset,
    input  logic        de,
    input  logic        hs,
    input  logic        vs,
    input  logic [4:0]  r,
    input  logic [5:0]  g,
    input  logic [4:0]  b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err_timing,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_v_active,
    output logic [11:0] meas_v_total,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);
    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [11:0] H_ACT_C = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_C = 12'(V_ACTIVE);
    localparam logic [3:0]  LOCK_C  = 4'(LOCK_FRAMES);

    state_t      state_q, state_d;
    logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [15:0] rgb1_q, rgb1_d;
    logic [11:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, line_cnt_q, line_cnt_d, act_cnt_q, act_cnt_d;
    logic [11:0] h_ref_q, h_ref_d;
    logic        h_ref_vld_q, h_ref_vld_d, span_q, span_d;
    logic        run_err_q, run_err_d, vde_err_q, vde_err_d, h_mis_q, h_mis_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic        locked_q, locked_d, err_timing_q, err_timing_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] pix_rgb_q, pix_rgb_d;
    logic [11:0] meas_h_active_q, meas_h_active_d, meas_h_total_q, meas_h_total_d;
    logic [11:0] meas_v_active_q, meas_v_active_d, meas_v_total_q, meas_v_total_d;
    logic        hs_rise_s, vs_rise_s, de_fall_s, vde_s, h_sat_s, run_bad_s, h_bad_s;
    logic        frame_ok_s, lock_viol_s;
    logic [11:0] lines_s, acts_s;

`ifdef RGB_VIDEO_RX_CRC_EN
    logic [15:0] crc_run_q, crc_run_d, frame_crc_q, frame_crc_d;
    logic        crc_valid_q, crc_valid_d;

    function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`else
    assign frame_crc = 16'd0;
    assign crc_valid = 1'b0;
`endif

    // Next-state logic: input pipeline, timing counters, conformance tracking and lock FSM.
    always_comb begin
        de1_d  = de;
        hs1_d  = hs;
        vs1_d  = vs;
        rgb1_d = {r, g, b};
        de2_d  = de1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;

        hs_rise_s   = (hs1_q == HS_POL) && (hs2_q != HS_POL);
        vs_rise_s   = (vs1_q == VS_POL) && (vs2_q != VS_POL);
        de_fall_s   = !de1_q && de2_q;
        vde_s       = de1_q && (vs1_q == VS_POL);
        h_sat_s     = !hs_rise_s && (h_cnt_q == 12'd4094);
        // An hs landing on the same cycle as vs still belongs to the frame that is ending.
        lines_s     = line_cnt_q + {11'd0, hs_rise_s};
        acts_s      = act_cnt_q + {11'd0, de_fall_s};
        run_bad_s   = de_fall_s && ((de_cnt_q != H_ACT_C) || span_q);
        h_bad_s     = hs_rise_s && h_ref_vld_q && (h_cnt_q != h_ref_q);
        frame_ok_s  = !(run_err_q || run_bad_s || vde_err_q || vde_s || h_mis_q || h_bad_s)
                      && (acts_s == V_ACT_C);
        lock_viol_s = run_bad_s || vde_s || h_sat_s || (vs_rise_s && (acts_s != V_ACT_C));

        meas_h_total_d  = meas_h_total_q;
        meas_h_active_d = meas_h_active_q;
        meas_v_total_d  = meas_v_total_q;
        meas_v_active_d = meas_v_active_q;

        if (hs_rise_s) begin
            h_cnt_d        = 12'd1;
            meas_h_total_d = h_cnt_q;
        end else if (h_cnt_q != 12'hFFF) begin
            h_cnt_d = h_cnt_q + 12'd1;
        end else begin
            h_cnt_d = h_cnt_q;
        end

        // A run still high across hs restarts de_cnt and is marked invalid until it ends.
        if (hs_rise_s) begin
            de_cnt_d = {11'd0, de1_q};
            span_d   = de1_q && de2_q;
        end else if (de1_q) begin
            de_cnt_d = de_cnt_q + 12'd1;
            span_d   = span_q;
        end else begin
            de_cnt_d = de_cnt_q;
            span_d   = de_fall_s ? 1'b0 : span_q;
        end

        if (de_fall_s) begin
            meas_h_active_d = de_cnt_q;
        end else begin
            meas_h_active_d = meas_h_active_q;
        end

        if (vs_rise_s) begin
            line_cnt_d  = 12'd0;
            act_cnt_d   = 12'd0;
            run_err_d   = 1'b0;
            vde_err_d   = 1'b0;
            h_mis_d     = 1'b0;
            h_ref_vld_d = 1'b0;
            h_ref_d     = h_ref_q;
        end else begin
            line_cnt_d  = lines_s;
            act_cnt_d   = acts_s;
            run_err_d   = run_err_q | run_bad_s;
            vde_err_d   = vde_err_q | vde_s;
            h_mis_d     = h_mis_q | h_bad_s;
            if (hs_rise_s && !h_ref_vld_q) begin
                h_ref_vld_d = 1'b1;
                h_ref_d     = h_cnt_q;
            end else begin
                h_ref_vld_d = h_ref_vld_q;
                h_ref_d     = h_ref_q;
            end
        end

        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_timing_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_rise_s) begin
                    state_d    = MEASURE;
                    good_cnt_d = 4'd0;
                end else begin
                    state_d = SEARCH;
                end
            end
            MEASURE: begin
                if (vs_rise_s && frame_ok_s) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    state_d    = ((good_cnt_q + 4'd1) >= LOCK_C) ? LOCKED : MEASURE;
                end else if (vs_rise_s) begin
                    good_cnt_d = 4'd0;
                end else begin
                    good_cnt_d = good_cnt_q;
                end
            end
            LOCKED: begin
                if (lock_viol_s) begin
                    state_d      = SEARCH;
                    err_timing_d = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d      = (state_d == LOCKED);
        frame_start_d = vs_rise_s && (state_d == LOCKED);
        if (vs_rise_s && (state_q != SEARCH)) begin
            meas_v_total_d  = lines_s;
            meas_v_active_d = acts_s;
        end else begin
            meas_v_total_d  = meas_v_total_q;
            meas_v_active_d = meas_v_active_q;
        end

        pix_valid_d = de1_q && locked_q;
        pix_x_d     = hs_rise_s ? 10'd0 : de_cnt_q[9:0];
        pix_y_d     = act_cnt_q[9:0];
        pix_rgb_d   = rgb1_q;

`ifdef RGB_VIDEO_RX_CRC_EN
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (vs_rise_s) begin
            crc_run_d = 16'hFFFF;
            if (state_d == LOCKED) begin
                frame_crc_d = crc_run_q;
                crc_valid_d = 1'b1;
            end else begin
                frame_crc_d = frame_crc_q;
            end
        end else if (de1_q) begin
            crc_run_d = crc16_ccitt(crc_run_q, rgb1_q);
        end else begin
            crc_run_d = crc_run_q;
        end
`endif
    end

    // State registers; sync regs reset to the deasserted sync level so no edge is seen at start.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            de1_q <= 1'b0;    hs1_q <= ~HS_POL; vs1_q <= ~VS_POL; rgb1_q <= 16'd0;
            de2_q <= 1'b0;    hs2_q <= ~HS_POL; vs2_q <= ~VS_POL;
            h_cnt_q <= 12'd0; de_cnt_q <= 12'd0; line_cnt_q <= 12'd0; act_cnt_q <= 12'd0;
            h_ref_q <= 12'd0; h_ref_vld_q <= 1'b0; span_q <= 1'b0;
            run_err_q <= 1'b0; vde_err_q <= 1'b0; h_mis_q <= 1'b0; good_cnt_q <= 4'd0;
            pix_valid_q <= 1'b0; pix_x_q <= 10'd0; pix_y_q <= 10'd0; pix_rgb_q <= 16'd0;
            frame_start_q <= 1'b0; locked_q <= 1'b0; err_timing_q <= 1'b0;
            meas_h_active_q <= 12'd0; meas_h_total_q <= 12'd0;
            meas_v_active_q <= 12'd0; meas_v_total_q <= 12'd0;
`ifdef RGB_VIDEO_RX_CRC_EN
            crc_run_q <= 16'hFFFF; frame_crc_q <= 16'd0; crc_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            de1_q <= de1_d;   hs1_q <= hs1_d;   vs1_q <= vs1_d;   rgb1_q <= rgb1_d;
            de2_q <= de2_d;   hs2_q <= hs2_d;   vs2_q <= vs2_d;
            h_cnt_q <= h_cnt_d; de_cnt_q <= de_cnt_d; line_cnt_q <= line_cnt_d; act_cnt_q <= act_cnt_d;
            h_ref_q <= h_ref_d; h_ref_vld_q <= h_ref_vld_d; span_q <= span_d;
            run_err_q <= run_err_d; vde_err_q <= vde_err_d; h_mis_q <= h_mis_d; good_cnt_q <= good_cnt_d;
            pix_valid_q <= pix_valid_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_rgb_q <= pix_rgb_d;
            frame_start_q <= frame_start_d; locked_q <= locked_d; err_timing_q <= err_timing_d;
            meas_h_active_q <= meas_h_active_d; meas_h_total_q <= meas_h_total_d;
            meas_v_active_q <= meas_v_active_d; meas_v_total_q <= meas_v_total_d;
`ifdef RGB_VIDEO_RX_CRC_EN
            crc_run_q <= crc_run_d; frame_crc_q <= frame_crc_d; crc_valid_q <= crc_valid_d;
`endif
        end
    end

    assign pix_valid     = pix_valid_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign pix_rgb       = pix_rgb_q;
    assign frame_start   = frame_start_q;
    assign locked        = locked_q;
    assign err_timing    = err_timing_q;
    assign meas_h_active = meas_h_active_q;
    assign meas_h_total  = meas_h_total_q;
    assign meas_v_active = meas_v_active_q;
    assign meas_v_total  = meas_v_total_q;
endmodule
